// File: rtl/lu_pkg.sv
// Shared definitions for the bitwise logic unit: op encodings and flag bit ordering.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lu_pkg;

  // Width of the op select field.
  localparam int LU_OP_W = 3;

  // Op encodings; b is ignored for NOT and PASS.
  typedef enum logic [LU_OP_W-1:0] {
    LU_OP_AND  = 3'b000,
    LU_OP_OR   = 3'b001,
    LU_OP_XOR  = 3'b010,
    LU_OP_NAND = 3'b011,
    LU_OP_NOR  = 3'b100,
    LU_OP_XNOR = 3'b101,
    LU_OP_NOT  = 3'b110,
    LU_OP_PASS = 3'b111
  } lu_op_e;

  // Packed flag field is {parity, ones, zero}; these are the bit positions.
  localparam int LU_FLAG_W      = 3;
  localparam int LU_FLAG_ZERO   = 0;
  localparam int LU_FLAG_ONES   = 1;
  localparam int LU_FLAG_PARITY = 2;

endpackage

// File: rtl/lu_core.sv
// Combinational WIDTH-bit bitwise logic unit producing a result and its {parity,ones,zero} flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is captured.
module lu_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [LU_OP_W-1:0]   op,
  output logic [WIDTH-1:0]     y,
  output logic [LU_FLAG_W-1:0] flags
);

  // Select the bitwise operation.
  always_comb begin
    y = '0;
    case (op)
      LU_OP_AND:  y = a & b;
      LU_OP_OR:   y = a | b;
      LU_OP_XOR:  y = a ^ b;
      LU_OP_NAND: y = ~(a & b);
      LU_OP_NOR:  y = ~(a | b);
      LU_OP_XNOR: y = ~(a ^ b);
      LU_OP_NOT:  y = ~a;
      default:    y = a;
    endcase
  end

  // Derive the status flags from the result.
  always_comb begin
    flags                 = '0;
    flags[LU_FLAG_ZERO]   = ~|y;
    flags[LU_FLAG_ONES]   = &y;
    flags[LU_FLAG_PARITY] = ^y;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with valid/ready handshake and a 2-entry result buffer; optional pop counter under LU_STATS_EN.
// Latency: result visible the cycle after the push edge; held while the consumer stalls.
// Backpressure: in_ready drops when both buffer entries are full; empty output drives y and flags to 0.
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 4
`ifdef LU_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               flag_zero,
  output logic               flag_ones,
  output logic               flag_parity
`ifdef LU_STATS_EN
  ,
  output logic [CNT_W-1:0]   txn_count
`endif
);

  logic [WIDTH-1:0]     res_y;
  logic [LU_FLAG_W-1:0] res_f;

  logic [1:0]           occ_q, occ_d;
  logic [WIDTH-1:0]     head_y_q, head_y_d;
  logic [LU_FLAG_W-1:0] head_f_q, head_f_d;
  logic [WIDTH-1:0]     tail_y_q, tail_y_d;
  logic [LU_FLAG_W-1:0] tail_f_q, tail_f_d;

  logic push;
  logic pop;

  lu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (a),
    .b     (b),
    .op    (op),
    .y     (res_y),
    .flags (res_f)
  );

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head entry drives the outputs; everything reads zero while empty.
  always_comb begin
    y           = out_valid ? head_y_q : '0;
    flag_zero   = out_valid & head_f_q[LU_FLAG_ZERO];
    flag_ones   = out_valid & head_f_q[LU_FLAG_ONES];
    flag_parity = out_valid & head_f_q[LU_FLAG_PARITY];
  end

  // Two-entry FIFO next state: head is always the oldest entry, tail only used at occupancy 2.
  always_comb begin
    occ_d    = occ_q;
    head_y_d = head_y_q;
    head_f_d = head_f_q;
    tail_y_d = tail_y_q;
    tail_f_d = tail_f_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_y_d = res_y;
          head_f_d = res_f;
          occ_d    = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_y_d = res_y;
          head_f_d = res_f;
        end else if (push) begin
          tail_y_d = res_y;
          tail_f_d = res_f;
          occ_d    = 2'd2;
        end else if (pop) begin
          occ_d    = 2'd0;
        end
      end
      default: begin
        // Full: no push possible, a pop promotes the tail.
        if (pop) begin
          head_y_d = tail_y_q;
          head_f_d = tail_f_q;
          occ_d    = 2'd1;
        end
      end
    endcase
  end

  // Buffer state registers, discarded asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= 2'd0;
      head_y_q <= '0;
      head_f_q <= '0;
      tail_y_q <= '0;
      tail_f_q <= '0;
    end else begin
      occ_q    <= occ_d;
      head_y_q <= head_y_d;
      head_f_q <= head_f_d;
      tail_y_q <= tail_y_d;
      tail_f_q <= tail_f_d;
    end
  end

`ifdef LU_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of completed (popped) transactions.
  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign txn_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe at WIDTH=4 (CNT_W=3 when LU_STATS_EN is defined).
// Stimulus pushes hand-computed results into a queue; a negedge monitor pops and compares.
// Inputs are driven 2 time units after the rising edge; outputs sampled on the falling edge.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
  logic       flag_zero;
  logic       flag_ones;
  logic       flag_parity;
`ifdef LU_STATS_EN
  logic [2:0] txn_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  logic [3:0] allops_exp [8];
  logic [3:0] tmp_y;

  logic_unit_pipe #(
    .WIDTH (4)
`ifdef LU_STATS_EN
    ,
    .CNT_W (3)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .flag_zero   (flag_zero),
    .flag_ones   (flag_ones),
    .flag_parity (flag_parity)
`ifdef LU_STATS_EN
    ,
    .txn_count   (txn_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one operand set; called 2 units after a rising edge, returns 2 units after the accepting edge.
  task automatic send(input logic [3:0] ta, input logic [3:0] tbv, input logic [2:0] top,
                      input logic [3:0] ey);
    bit taken;
    taken    = 1'b0;
    a        = ta;
    b        = tbv;
    op       = top;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !taken; k++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1'b1;
        exp_q.push_back(ey);
      end
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    if (!taken) check("send_accept_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare every popped result against the scoreboard; empty output must read zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("y", 32'(y), 32'(e));
          check("flags", {29'd0, flag_parity, flag_ones, flag_zero},
                {29'd0, ^e, (e == 4'hF), (e == 4'h0)});
        end
      end else if (!out_valid) begin
        check("empty_outputs_zero", {28'd0, y} | {29'd0, flag_parity, flag_ones, flag_zero}, 32'd0);
      end
    end
  end

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    allops_exp[0] = 4'b1000; allops_exp[1] = 4'b1110;
    allops_exp[2] = 4'b0110; allops_exp[3] = 4'b0111;
    allops_exp[4] = 4'b0001; allops_exp[5] = 4'b1001;
    allops_exp[6] = 4'b0011; allops_exp[7] = 4'b1100;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    #1 rst_n = 1'b0;
    #2;
    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_y", 32'(y), 32'd0);
    check("rst_flags", {29'd0, flag_parity, flag_ones, flag_zero}, 32'd0);
`ifdef LU_STATS_EN
    check("rst_txn_count", 32'(txn_count), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;

    // NAND sweep with b=1111: also proves occupancy stays 1 with simultaneous push/pop
    for (int i = 0; i < 16; i++) begin
      tmp_y = 4'(15 - i);
      send(4'(i), 4'b1111, 3'b011, tmp_y);
      check("stream_out_valid", 32'(out_valid), 32'd1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
`ifdef LU_STATS_EN
      check("txn_count_sat", 32'(txn_count), (i < 7) ? 32'(i) : 32'd7);
`endif
    end

    // All ops with a=1100, b=1010
    for (int i = 0; i < 8; i++) begin
      send(4'b1100, 4'b1010, 3'(i), allops_exp[i]);
    end
    @(posedge clk); #2;

    // Backpressure: two accepted, third refused while stalled
    out_ready = 1'b0;
    send(4'b1100, 4'b1010, 3'b000, 4'b1000);
    send(4'b1100, 4'b1010, 3'b001, 4'b1110);
    a = 4'b1100; b = 4'b1010; op = 3'b010; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_head_held", 32'(y), 32'b1000);
      a = 4'(k);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_in_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    check("bp_drained", 32'(out_valid), 32'd0);
`ifdef LU_STATS_EN
    check("txn_count_hold_max", 32'(txn_count), 32'd7);
`endif

    // Reset mid-operation with two entries held
    out_ready = 1'b0;
    send(4'b0000, 4'b0000, 3'b000, 4'b0000);
    send(4'b0011, 4'b0101, 3'b001, 4'b0111);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_flags", {29'd0, flag_parity, flag_ones, flag_zero}, 32'd0);
`ifdef LU_STATS_EN
    check("midrst_txn_count", 32'(txn_count), 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    send(4'b1111, 4'b0000, 3'b111, 4'b1111);
    check("post_rst_first_push_visible", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    check("post_rst_no_stale", 32'(out_valid), 32'd0);

    // Drain and confirm every expected result was seen
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
